// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte packets, applies the signed
// deltas to a clamped cursor position and publishes button levels. A
// mid-packet idle timeout drops a partial packet so a lost byte cannot
// leave the decoder permanently out of frame.
module mouse_packet_decoder #(
  parameter int MAX_X   = 639,
  parameter int MAX_Y   = 479,
  parameter int INIT_X  = 320,
  parameter int INIT_Y  = 240,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic       mouse_left,
  output logic       mouse_right,
  output logic       mouse_middle,
  output logic       pkt_strobe,
  output logic       sync_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
  localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} state_t;

  state_t        state_q, state_d;
  // status byte minus the always-one sync bit: {yov, xov, ysign, xsign, mid, right, left}
  logic [6:0]    stat_q, stat_d;
  logic [7:0]    dxb_q, dxb_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [2:0]    btn_q, btn_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;

  logic signed [11:0] dx_s, dy_s, nx, ny;

  // Next-state, delta arithmetic, clamping and timeout detection.
  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    dxb_d    = dxb_q;
    x_d      = x_q;
    y_d      = y_q;
    btn_d    = btn_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    idle_d   = (state_q == BYTE0 || rx_valid) ? '0 : idle_q + 1'b1;

    // Overflowed axes contribute no motion; dy is the byte arriving now.
    dx_s = stat_q[5] ? 12'sd0 : {{4{stat_q[3]}}, dxb_q};
    dy_s = stat_q[6] ? 12'sd0 : {{4{stat_q[4]}}, rx_byte};
    nx   = $signed({2'b00, x_q}) + dx_s;
    ny   = $signed({2'b00, y_q}) - dy_s;

    if (rx_valid) begin
      case (state_q)
        BYTE0: begin
          if (rx_byte[3]) begin
            stat_d  = {rx_byte[7:4], rx_byte[2:0]};
            state_d = BYTE1;
          end else begin
            err_d = 1'b1;
          end
        end
        BYTE1: begin
          dxb_d   = rx_byte;
          state_d = BYTE2;
        end
        BYTE2: begin
          if (nx < 12'sd0)        x_d = '0;
          else if (nx > MAX_X_S)  x_d = 10'(MAX_X);
          else                    x_d = nx[9:0];
          if (ny < 12'sd0)        y_d = '0;
          else if (ny > MAX_Y_S)  y_d = 10'(MAX_Y);
          else                    y_d = ny[9:0];
          btn_d    = stat_q[2:0];
          strobe_d = 1'b1;
          state_d  = BYTE0;
        end
        default: state_d = BYTE0;
      endcase
    end else if (state_q != BYTE0 && idle_q == CW'(TIMEOUT - 1)) begin
      // This cycle is the TIMEOUT-th idle one: abandon the partial packet.
      state_d = BYTE0;
      idle_d  = '0;
      err_d   = 1'b1;
    end
  end

  // State and registered outputs; reset wins over any incoming byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BYTE0;
      stat_q   <= '0;
      dxb_q    <= '0;
      idle_q   <= '0;
      x_q      <= 10'(INIT_X);
      y_q      <= 10'(INIT_Y);
      btn_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      dxb_q    <= dxb_d;
      idle_q   <= idle_d;
      x_q      <= x_d;
      y_q      <= y_d;
      btn_q    <= btn_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign mouse_x      = x_q;
  assign mouse_y      = y_q;
  assign mouse_left   = btn_q[0];
  assign mouse_right  = btn_q[1];
  assign mouse_middle = btn_q[2];
  assign pkt_strobe   = strobe_q;
  assign sync_err     = err_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Bench for mouse_packet_decoder: directed scenarios plus randomized packets
// against an integer cursor model.
module tb_mouse_packet_decoder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [9:0] mouse_x, mouse_y;
  logic       mouse_left, mouse_right, mouse_middle;
  logic       pkt_strobe, sync_err;

  int checks = 0;
  int failures = 0;

  int mx, my;
  logic [2:0] mb;

  mouse_packet_decoder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .mouse_right(mouse_right), .mouse_middle(mouse_middle),
    .pkt_strobe(pkt_strobe), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Present one byte for exactly one rising edge; called and returns on a negedge.
  task automatic put(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference: screen cursor moved by signed 9-bit deltas, clamped to the screen.
  task automatic model_pkt(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    int dx, dy;
    dx = s[6] ? 0 : (s[4] ? int'(a) - 256 : int'(a));
    dy = s[7] ? 0 : (s[5] ? int'(b) - 256 : int'(b));
    mx = mx + dx; if (mx < 0) mx = 0; if (mx > 639) mx = 639;
    my = my - dy; if (my < 0) my = 0; if (my > 479) my = 479;
    mb = s[2:0];
  endtask

  task automatic pkt(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    put(s); put(a); put(b);
    model_pkt(s, a, b);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_byte = 8'h09; rx_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    mx = 320; my = 240; mb = 3'b000;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mouse_x !== 10'd320 || mouse_y !== 10'd240) begin failures++;
      $display("FAIL reset_pos got %0d/%0d want 320/240", mouse_x, mouse_y); end
    checks++; if ({mouse_middle, mouse_right, mouse_left, pkt_strobe, sync_err} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got %b want 00000", {mouse_middle, mouse_right, mouse_left, pkt_strobe, sync_err}); end
  endtask

  task automatic test_basic();
    pkt(8'h09, 8'h05, 8'h03);
    checks++; if (mouse_x !== 10'd325 || mouse_y !== 10'd237 || mouse_left !== 1'b1) begin failures++;
      $display("FAIL basic_pos got x=%0d y=%0d l=%b want 325/237/1", mouse_x, mouse_y, mouse_left); end
    checks++; if (pkt_strobe !== 1'b1 || sync_err !== 1'b0) begin failures++;
      $display("FAIL basic_strobe got s=%b e=%b want 1/0", pkt_strobe, sync_err); end
    @(negedge clk);
    checks++; if (pkt_strobe !== 1'b0) begin failures++;
      $display("FAIL basic_strobe_width got %b want 0", pkt_strobe); end
  endtask

  task automatic test_clamp_low();
    int y0;
    repeat (3) pkt(8'h18, 8'h00, 8'h00);
    pkt(8'h08, 8'h05, 8'h00);
    checks++; if (mouse_x !== 10'd5) begin failures++;
      $display("FAIL setup_x5 got %0d want 5", mouse_x); end
    y0 = my;
    pkt(8'h18, 8'hF6, 8'h00);
    checks++; if (mouse_x !== 10'd0 || mouse_y !== 10'(y0)) begin failures++;
      $display("FAIL clamp_low got x=%0d y=%0d want 0/%0d", mouse_x, mouse_y, y0); end
    checks++; if ({mouse_middle, mouse_right, mouse_left} !== 3'b000 || pkt_strobe !== 1'b1) begin failures++;
      $display("FAIL clamp_low_btn got %b s=%b want 000/1", {mouse_middle, mouse_right, mouse_left}, pkt_strobe); end
  endtask

  task automatic test_overflow();
    int x0, y0;
    x0 = mx; y0 = my;
    pkt(8'h88, 8'h00, 8'h7F);
    checks++; if (mouse_y !== 10'(y0) || mouse_x !== 10'(x0) || pkt_strobe !== 1'b1) begin failures++;
      $display("FAIL y_overflow got x=%0d y=%0d s=%b want %0d/%0d/1", mouse_x, mouse_y, pkt_strobe, x0, y0); end
    pkt(8'h4C, 8'h7F, 8'h01);
    checks++; if (mouse_x !== 10'(x0) || mouse_y !== 10'(y0 - 1) || mouse_middle !== 1'b1) begin failures++;
      $display("FAIL x_overflow got x=%0d y=%0d m=%b want %0d/%0d/1", mouse_x, mouse_y, mouse_middle, x0, y0 - 1); end
  endtask

  task automatic test_discard();
    int x0, y0;
    x0 = mx; y0 = my;
    put(8'h05);
    checks++; if (sync_err !== 1'b1 || pkt_strobe !== 1'b0) begin failures++;
      $display("FAIL discard_err got e=%b s=%b want 1/0", sync_err, pkt_strobe); end
    @(negedge clk);
    checks++; if (sync_err !== 1'b0) begin failures++;
      $display("FAIL discard_err_width got %b want 0", sync_err); end
    pkt(8'h0A, 8'h01, 8'h01);
    checks++; if (mouse_right !== 1'b1 || mouse_x !== 10'(x0 + 1) || mouse_y !== 10'(y0 - 1) || pkt_strobe !== 1'b1) begin failures++;
      $display("FAIL after_discard got r=%b x=%0d y=%0d want 1/%0d/%0d", mouse_right, mouse_x, mouse_y, x0 + 1, y0 - 1); end
  endtask

  task automatic test_timeout();
    int x0, y0, hit;
    logic [2:0] b0;
    logic strobe_seen;
    x0 = mx; y0 = my; b0 = mb; hit = -1; strobe_seen = 1'b0;
    put(8'h08); put(8'h01);
    for (int i = 1; i <= TO + 5; i++) begin
      @(negedge clk);
      if (pkt_strobe) strobe_seen = 1'b1;
      if (sync_err && hit < 0) hit = i;
    end
    checks++; if (hit != TO) begin failures++;
      $display("FAIL timeout_cycle got %0d want %0d", hit, TO); end
    checks++; if (strobe_seen || mouse_x !== 10'(x0) || mouse_y !== 10'(y0) || {mouse_middle, mouse_right, mouse_left} !== b0) begin failures++;
      $display("FAIL timeout_hold got x=%0d y=%0d s=%b want %0d/%0d/0", mouse_x, mouse_y, strobe_seen, x0, y0); end
    pkt(8'h08, 8'h00, 8'h00);
    checks++; if (pkt_strobe !== 1'b1 || mouse_x !== 10'(mx) || mouse_y !== 10'(my)) begin failures++;
      $display("FAIL after_timeout got s=%b x=%0d y=%0d want 1/%0d/%0d", pkt_strobe, mouse_x, mouse_y, mx, my); end
    // A byte landing on the expiry cycle must be accepted instead.
    hit = 0;
    put(8'h08); put(8'h03);
    repeat (TO - 1) begin @(negedge clk); if (sync_err) hit++; end
    put(8'h02);
    model_pkt(8'h08, 8'h03, 8'h02);
    checks++; if (hit != 0 || sync_err !== 1'b0 || pkt_strobe !== 1'b1 || mouse_x !== 10'(mx) || mouse_y !== 10'(my)) begin failures++;
      $display("FAIL expiry_race got errs=%0d e=%b s=%b x=%0d y=%0d want 0/0/1/%0d/%0d", hit, sync_err, pkt_strobe, mouse_x, mouse_y, mx, my); end
  endtask

  task automatic test_clamp_high();
    repeat (3) pkt(8'h08, 8'hFF, 8'h00);
    pkt(8'h18, 8'hFC, 8'h00);
    repeat (2) pkt(8'h08, 8'h00, 8'hFF);
    pkt(8'h28, 8'h00, 8'hFE);
    checks++; if (mouse_x !== 10'd635 || mouse_y !== 10'd2) begin failures++;
      $display("FAIL setup_635_2 got %0d/%0d want 635/2", mouse_x, mouse_y); end
    pkt(8'h08, 8'h14, 8'h0A);
    checks++; if (mouse_x !== 10'd639 || mouse_y !== 10'd0) begin failures++;
      $display("FAIL clamp_high got %0d/%0d want 639/0", mouse_x, mouse_y); end
    put(8'h08); put(8'h14);
    do_reset();
    checks++; if (mouse_x !== 10'd320 || mouse_y !== 10'd240 || pkt_strobe !== 1'b0) begin failures++;
      $display("FAIL mid_reset got x=%0d y=%0d s=%b want 320/240/0", mouse_x, mouse_y, pkt_strobe); end
    put(8'h05);
    checks++; if (sync_err !== 1'b1 || pkt_strobe !== 1'b0 || mouse_x !== 10'd320) begin failures++;
      $display("FAIL post_reset_byte0 got e=%b s=%b x=%0d want 1/0/320", sync_err, pkt_strobe, mouse_x); end
  endtask

  task automatic test_random();
    logic [7:0] s, a, b, j;
    int bad;
    bad = 0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom); j[3] = 1'b0;
        put(j);
        if (sync_err !== 1'b1 || pkt_strobe !== 1'b0) bad++;
        @(negedge clk);
      end
      s = 8'($urandom); s[3] = 1'b1;
      a = 8'($urandom); b = 8'($urandom);
      put(s); repeat ($urandom_range(0, TO - 3)) @(negedge clk);
      put(a); repeat ($urandom_range(0, TO - 3)) @(negedge clk);
      put(b);
      model_pkt(s, a, b);
      if (mouse_x !== 10'(mx) || mouse_y !== 10'(my) || {mouse_middle, mouse_right, mouse_left} !== mb
          || pkt_strobe !== 1'b1 || sync_err !== 1'b0) begin
        bad++;
        $display("pkt %0d: got x=%0d y=%0d b=%b s=%b expected x=%0d y=%0d b=%b", n, mouse_x, mouse_y,
                 {mouse_middle, mouse_right, mouse_left}, pkt_strobe, mx, my, mb);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL random_packets got %0d bad events want 0", bad); end
  endtask

  initial begin
    rst = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clamp_low();
    test_overflow();
    test_discard();
    test_timeout();
    test_clamp_high();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_packet_decoder.md
MOUSE_PACKET_DECODER -- requirements
Module: mouse_packet_decoder

Interface
REQ-001 The block SHALL take parameter MAX_X, default 639, as the largest legal cursor X (640-wide framebuffer).
REQ-002 The block SHALL take parameter MAX_Y, default 479, as the largest legal cursor Y.
REQ-003 The block SHALL take parameter INIT_X, default 320, as the cursor X after reset.
REQ-004 The block SHALL take parameter INIT_Y, default 240, as the cursor Y after reset.
REQ-005 The block SHALL take parameter TIMEOUT, default 100000, as the number of idle clk cycles mid-packet before resync.
REQ-006 The block SHALL have port clk, input, 1 bit, system clock; reset rst, synchronous, active-high; clock clk.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port rx_byte, input, 8 bits, byte from the PS/2 serial receiver.
REQ-009 The block SHALL have port rx_valid, input, 1 bit, single-cycle strobe qualifying rx_byte.
REQ-010 The block SHALL have port mouse_x, output, 10 bits, cursor X, in 0..MAX_X.
REQ-011 The block SHALL have port mouse_y, output, 10 bits, cursor Y, in 0..MAX_Y, with screen-down positive.
REQ-012 The block SHALL have ports mouse_left, mouse_right and mouse_middle, each output, 1 bit, registered button levels.
REQ-013 The block SHALL have port pkt_strobe, output, 1 bit, one-cycle pulse per decoded packet.
REQ-014 The block SHALL have port sync_err, output, 1 bit, one-cycle pulse per discarded byte or timed-out packet.

Function
REQ-015 The block SHALL implement the states BYTE0 (status), BYTE1 (dX) and BYTE2 (dY), and SHALL advance state only on rx_valid.
REQ-016 In BYTE0, a byte with bit3=1 SHALL be stored as status and the state SHALL go to BYTE1; a byte with bit3=0 SHALL be discarded, SHALL pulse sync_err for one cycle, and the state SHALL remain BYTE0.
REQ-017 In BYTE1, the byte SHALL be stored as dX and the state SHALL go to BYTE2.
REQ-018 In BYTE2, the byte SHALL be taken as dY and the state SHALL return to BYTE0.
REQ-019 The edge that accepts the byte in BYTE2 SHALL update mouse_x, mouse_y and all button outputs together, and pkt_strobe SHALL be high in the following cycle only.
REQ-020 The deltas SHALL be 9-bit two's complement: dx = {status[4], dX} and dy = {status[5], dY}.
REQ-021 If status[6] (X overflow) is set, dx SHALL be treated as 0; if status[7] (Y overflow) is set, dy SHALL be treated as 0; buttons SHALL still update.
REQ-022 The new positions SHALL be nx = mouse_x + dx and ny = mouse_y - dy, computed at 12-bit signed width.
REQ-023 Each new position SHALL be clamped: a value below 0 SHALL become 0, and a value above MAX_X or MAX_Y SHALL become MAX_X or MAX_Y respectively.
REQ-024 Button outputs SHALL be set as mouse_left=status[0], mouse_right=status[1] and mouse_middle=status[2].
REQ-025 The idle counter SHALL count cycles without rx_valid while the state is BYTE1 or BYTE2, SHALL clear on every rx_valid, and SHALL hold at 0 in BYTE0.
REQ-026 When the idle counter reaches TIMEOUT, the block SHALL discard the partial packet, SHALL return to BYTE0, SHALL pulse sync_err for one cycle, and SHALL leave the outputs unchanged.
REQ-027 If rx_valid coincides with timeout expiry, the byte SHALL be accepted and no timeout SHALL occur.
REQ-028 pkt_strobe and sync_err SHALL never assert in the same cycle.
REQ-029 Outputs SHALL change only on a packet completion (REQ-019) or on reset.

Reset
REQ-030 While rst is high at a clk edge, the block SHALL set state=BYTE0, idle counter=0, mouse_x=INIT_X, mouse_y=INIT_Y, all buttons=0, pkt_strobe=0 and sync_err=0.
REQ-031 Reset mid-packet SHALL discard the partial packet, and the first byte after reset SHALL be treated as a BYTE0 candidate.
REQ-032 rx_valid SHALL be ignored during any cycle in which rst is high.

Verification
REQ-033 The bench SHALL check: after reset, bytes 0x09, 0x05, 0x03 -> mouse_left=1, mouse_x=325, mouse_y=237, one pkt_strobe pulse.
REQ-034 The bench SHALL check: with mouse_x=5, bytes 0x18, 0xF6, 0x00 -> mouse_x=0 (clamped), mouse_y unchanged, all buttons 0.
REQ-035 The bench SHALL check: bytes 0x88, 0x00, 0x7F -> mouse_y unchanged (Y overflow), pkt_strobe pulses.
REQ-036 The bench SHALL check: byte 0x05 while in BYTE0 -> sync_err pulse, no state change; a following 0x0A, 0x01, 0x01 -> mouse_right=1, x+1, y-1.
REQ-037 The bench SHALL check: bytes 0x08, 0x01, then TIMEOUT idle cycles -> sync_err pulse, outputs unchanged; the next 0x08, 0x00, 0x00 -> pkt_strobe pulse.
REQ-038 The bench SHALL check: with mouse_x=635 and mouse_y=2, bytes 0x08, 0x14, 0x0A -> mouse_x=639 and mouse_y=0; reset asserted after 0x08, 0x14 -> outputs return to 320/240 and no pkt_strobe.
